// File: rtl/cam_pkg.sv
// Shared types and default crop geometry for the camera capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } cam_state_t;

  typedef logic [15:0] rgb565_t;

  localparam int CROP_W_DEFAULT = 235;
  localparam int CROP_H_DEFAULT = 235;

endpackage

// File: rtl/cam_byte_assembler.sv
// Pairs incoming camera bytes (high byte first) into RGB565 pixels.
module cam_byte_assembler
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clear,
  input  logic [7:0] data_in,
  output logic       pix_done,
  output rgb565_t    pixel
);

  logic       phase;
  logic [7:0] high_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 1'b0;
      high_byte <= 8'd0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (en) begin
      if (!phase) high_byte <= data_in;
      phase <= ~phase;
    end
  end

  // The low byte is taken straight from the bus on the completing cycle.
  assign pix_done = en & phase & ~clear;
  assign pixel    = {high_byte, data_in};

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture with crop window and memory write strobe.
// Optional build macro CAM_CAPTURE_ADDR_PATTERN_EN writes the address value as pixel data.
module cam_capture
  import cam_pkg::*;
#(
  parameter int CROP_W = CROP_W_DEFAULT,
  parameter int CROP_H = CROP_H_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data_in,
  output rgb565_t     data_out,
  output logic        write_en,
  output logic [15:0] addr,
  output logic        frame_done,
  output logic        busy,
  output cam_state_t  state_dbg
);

  localparam logic [16:0] CROP_W17 = 17'(CROP_W);
  localparam logic [16:0] CROP_H17 = 17'(CROP_H);
  localparam logic [15:0] CROP_W16 = 16'(CROP_W);

  cam_state_t  state;
  logic        vsync_q;
  logic        href_q;
  logic [15:0] pix_x;
  logic [15:0] line_y;
  logic        line_has_byte;
  logic        vsync_rise;
  logic        vsync_fall;
  logic        href_fall;
  logic        in_capture;
  logic        asm_en;
  logic        asm_clear;
  logic        pix_done;
  logic        in_crop;
  rgb565_t     pixel;
  logic [15:0] addr_next;

  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign href_fall  = ~href & href_q;
  assign in_capture = (state == CAPTURE);
  assign asm_en     = in_capture & href;
  // Frame end or line end discards any half-assembled pixel.
  assign asm_clear  = ~in_capture | vsync_rise | href_fall;
  assign in_crop    = ({1'b0, pix_x} < CROP_W17) && ({1'b0, line_y} < CROP_H17);
  assign addr_next  = line_y * CROP_W16 + pix_x;
  assign state_dbg  = state;

  cam_byte_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .en       (asm_en),
    .clear    (asm_clear),
    .data_in  (data_in),
    .pix_done (pix_done),
    .pixel    (pixel)
  );

  // write_en is a one-cycle strobe with no backpressure; data_out/addr hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      pix_x         <= 16'd0;
      line_y        <= 16'd0;
      line_has_byte <= 1'b0;
      data_out      <= '0;
      addr          <= 16'd0;
      write_en      <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      href_q     <= href;
      write_en   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          if (vsync_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          if (vsync_rise) begin
            frame_done    <= 1'b1;
            pix_x         <= 16'd0;
            line_y        <= 16'd0;
            line_has_byte <= 1'b0;
            if (start) begin
              state <= WAIT_FRAME;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (href_fall) begin
            pix_x         <= 16'd0;
            line_has_byte <= 1'b0;
            if (line_has_byte && line_y != 16'hFFFF) line_y <= line_y + 16'd1;
          end else if (href) begin
            line_has_byte <= 1'b1;
            if (pix_done) begin
              if (in_crop) begin
                write_en <= 1'b1;
                addr     <= addr_next;
`ifdef CAM_CAPTURE_ADDR_PATTERN_EN
                data_out <= addr_next;
`else
                data_out <= pixel;
`endif
              end
              if (pix_x != 16'hFFFF) pix_x <= pix_x + 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
